// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared ISA encodings, ALU op codes, redirect type codes, FSM states, trap vector
package decode_stage_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0040;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [1:0] PC_BRANCH = 2'b00;
  localparam logic [1:0] PC_JR     = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;
  typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_SQUASH} state_e;
  function automatic logic [2:0] alu_of(input logic [5:0] funct);
    return funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND :
           funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/decode_stage_reg_bank.sv
// reg_bank: 32x32 register bank, 2 read / 1 write ports, r0 reads 0 (clock, reset active-low sync, we/wa/wd write, ra1/ra2 -> rd1/rd2); DECODE_BYPASS_EN forwards same-cycle write to reads
module reg_bank (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end
  always_ff @(posedge clock) begin
    if (!reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
`ifdef DECODE_BYPASS_EN
  assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];
`else
  assign rd1 = ra1 == '0 ? '0 : regs_q[ra1];
  assign rd2 = ra2 == '0 ? '0 : regs_q[ra2];
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage (if_id_* in, id_if_* combinational redirect out, wb_id_* writeback in, id_ex_* registered out, id_epc trap PC); DECODE_BYPASS_EN enables writeback bypass in the bank
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_instruc,
  input  logic [31:0] if_id_nextpc,
  input  logic        ex_if_stall,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_if_pcindex,
  input  logic        wb_id_writereg,
  input  logic [4:0]  wb_id_regdest,
  input  logic [31:0] wb_id_writedata,
  output logic [31:0] id_ex_rega,
  output logic [31:0] id_ex_regb,
  output logic [31:0] id_ex_imedext,
  output logic [4:0]  id_ex_regdest,
  output logic        id_ex_writereg,
  output logic        id_ex_alusrc,
  output logic        id_ex_memread,
  output logic        id_ex_memwrite,
  output logic [2:0]  id_ex_aluop,
  output logic [31:0] id_epc
);
  state_e state_q, state_d;
  logic [1:0]  pend_type_q, pend_type_d;
  logic [31:0] pend_tgt_q, pend_tgt_d, epc_q, epc_d;
  logic [31:0] rega_q, rega_d, regb_q, regb_d, imedext_q, imedext_d;
  logic [4:0]  regdest_q, regdest_d;
  logic        writereg_q, writereg_d, alusrc_q, alusrc_d;
  logic        memread_q, memread_d, memwrite_q, memwrite_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [31:0] instr, rs_val, rt_val, imm_ext, br_tgt, jmp_tgt, req_tgt;
  logic [5:0]  op, funct;
  logic        is_alu, is_jr, is_j, legal, illegal, taken, req, pend;
  logic [1:0]  req_type;
  assign instr = state_q == ST_SQUASH ? '0 : if_id_instruc;
  reg_bank u_bank (
    .clock (clock),
    .reset (reset),
    .we    (wb_id_writereg),
    .wa    (wb_id_regdest),
    .wd    (wb_id_writedata),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );
  always_comb begin
    op = instr[31:26];
    funct = instr[5:0];
    is_alu = op == OP_RTYPE && funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    is_jr = op == OP_RTYPE && funct == FN_JR;
    is_j = op == OP_J;
    legal = instr == '0 || is_alu || is_jr || op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    illegal = !legal;
    taken = (op == OP_BEQ && rs_val == rt_val) || (op == OP_BNE && rs_val != rt_val);
    req = illegal || taken || is_jr || is_j;
    req_type = illegal ? PC_TRAP : is_jr ? PC_JR : is_j ? PC_JUMP : PC_BRANCH;
    imm_ext = {{16{instr[15]}}, instr[15:0]};
    br_tgt = if_id_nextpc + imm_ext;
    jmp_tgt = {if_id_nextpc[31:26], instr[25:0]};
    req_tgt = illegal ? RESET_VECTOR : is_jr ? rs_val : is_j ? jmp_tgt : br_tgt;
  end
  always_comb begin
    state_d = state_q;
    pend_type_d = pend_type_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      ST_RUN:
        if (req && ex_if_stall) begin
          state_d = ST_PEND;
          pend_type_d = req_type;
          pend_tgt_d = req_tgt;
        end else if (illegal) state_d = ST_SQUASH;
      ST_PEND:
        if (!ex_if_stall) state_d = pend_type_q == PC_TRAP ? ST_SQUASH : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end
  always_comb begin
    pend = state_q == ST_PEND;
    id_if_selpcsource = reset && (pend || (state_q == ST_RUN && req && !ex_if_stall));
    id_if_selpctype = !reset ? '0 : pend ? pend_type_q : req_type;
    id_if_pcimd2ext = !reset ? '0 : pend ? pend_tgt_q : br_tgt;
    id_if_rega = !reset ? '0 : pend ? pend_tgt_q : rs_val;
    id_if_pcindex = !reset ? '0 : pend ? pend_tgt_q : jmp_tgt;
    epc_d = state_q == ST_RUN && illegal ? if_id_nextpc - 32'd1 : epc_q;
    writereg_d = is_alu || op inside {OP_ADDI, OP_LW};
    regdest_d = is_alu ? instr[15:11] : writereg_d ? instr[20:16] : '0;
    alusrc_d = op inside {OP_ADDI, OP_LW, OP_SW};
    memread_d = op == OP_LW;
    memwrite_d = op == OP_SW;
    aluop_d = is_alu ? alu_of(funct) : ALU_ADD;
    rega_d = rs_val;
    regb_d = rt_val;
    imedext_d = imm_ext;
  end
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_RUN;
    else state_q <= state_d;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_type_q <= '0;
      pend_tgt_q <= '0;
      epc_q <= '0;
      rega_q <= '0;
      regb_q <= '0;
      imedext_q <= '0;
      regdest_q <= '0;
      writereg_q <= 1'b0;
      alusrc_q <= 1'b0;
      memread_q <= 1'b0;
      memwrite_q <= 1'b0;
      aluop_q <= '0;
    end else begin
      pend_type_q <= pend_type_d;
      pend_tgt_q <= pend_tgt_d;
      epc_q <= epc_d;
      rega_q <= rega_d;
      regb_q <= regb_d;
      imedext_q <= imedext_d;
      regdest_q <= regdest_d;
      writereg_q <= writereg_d;
      alusrc_q <= alusrc_d;
      memread_q <= memread_d;
      memwrite_q <= memwrite_d;
      aluop_q <= aluop_d;
    end
  end
  assign id_ex_rega = rega_q;
  assign id_ex_regb = regb_q;
  assign id_ex_imedext = imedext_q;
  assign id_ex_regdest = regdest_q;
  assign id_ex_writereg = writereg_q;
  assign id_ex_alusrc = alusrc_q;
  assign id_ex_memread = memread_q;
  assign id_ex_memwrite = memwrite_q;
  assign id_ex_aluop = aluop_q;
  assign id_epc = epc_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus random stimulus against a behavioural decode model
module tb_decode_stage;
  logic        clock = 1'b0, reset = 1'b0, ex_if_stall = 1'b0;
  logic [31:0] if_id_instruc = '0, if_id_nextpc = '0;
  logic        wb_id_writereg = 1'b0;
  logic [4:0]  wb_id_regdest = '0;
  logic [31:0] wb_id_writedata = '0;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_epc;
  logic [4:0]  id_ex_regdest;
  logic        id_ex_writereg, id_ex_alusrc, id_ex_memread, id_ex_memwrite;
  logic [2:0]  id_ex_aluop;
  decode_stage dut (
    .clock(clock), .reset(reset), .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
    .ex_if_stall(ex_if_stall), .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
    .wb_id_writereg(wb_id_writereg), .wb_id_regdest(wb_id_regdest), .wb_id_writedata(wb_id_writedata),
    .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
    .id_ex_regdest(id_ex_regdest), .id_ex_writereg(id_ex_writereg), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite), .id_ex_aluop(id_ex_aluop),
    .id_epc(id_epc)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0;
  bit [31:0] m_regs [32];
  bit        m_pend, m_squash, e_wr, e_src, e_mr, e_mw, e_ops;
  bit [1:0]  m_ptype;
  bit [31:0] m_ptgt, m_epc, e_rega, e_regb, e_imm;
  bit [4:0]  e_dest;
  bit [2:0]  e_alu;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit [31:0] rd_reg(input bit [4:0] r);
    if (r == 0) return 0;
`ifdef DECODE_BYPASS_EN
    if (wb_id_writereg && wb_id_regdest == r) return wb_id_writedata;
`endif
    return m_regs[r];
  endfunction
  task automatic chk_redirect(input bit [1:0] typ, input bit [31:0] tgt);
    chk("redir_sel", id_if_selpcsource, 1);
    chk("redir_type", id_if_selpctype, typ);
    if (typ == 0) chk("redir_br_tgt", id_if_pcimd2ext, tgt);
    if (typ == 1) chk("redir_jr_tgt", id_if_rega, tgt);
    if (typ == 2) chk("redir_j_tgt", id_if_pcindex, tgt);
  endtask
  task automatic drive(input bit [31:0] ins, input bit [31:0] npc, input bit st, input bit we,
                       input bit [4:0] wr, input bit [31:0] wd);
    bit [31:0] ie, rs_v, rt_v, sx, tgt;
    bit [5:0]  op, fn;
    bit        ill, redir, wrt, src, mr, mw;
    bit [4:0]  dst;
    bit [2:0]  alu;
    bit [1:0]  typ;
    if_id_instruc = ins; if_id_nextpc = npc; ex_if_stall = st;
    wb_id_writereg = we; wb_id_regdest = wr; wb_id_writedata = wd;
    #2;
    ie = m_squash ? 32'h0 : ins;
    op = ie[31:26]; fn = ie[5:0];
    rs_v = rd_reg(ie[25:21]); rt_v = rd_reg(ie[20:16]);
    sx = {{16{ie[15]}}, ie[15:0]};
    {ill, redir, wrt, src, mr, mw, dst, alu, typ, tgt} = '0;
    case (op)
      6'h00:
        if (ie != 0)
          case (fn)
            6'h20: begin wrt = 1; dst = ie[15:11]; alu = 0; end
            6'h22: begin wrt = 1; dst = ie[15:11]; alu = 1; end
            6'h24: begin wrt = 1; dst = ie[15:11]; alu = 2; end
            6'h25: begin wrt = 1; dst = ie[15:11]; alu = 3; end
            6'h2A: begin wrt = 1; dst = ie[15:11]; alu = 4; end
            6'h08: begin redir = 1; typ = 1; tgt = rs_v; end
            default: ill = 1;
          endcase
      6'h08: begin wrt = 1; dst = ie[20:16]; src = 1; end
      6'h23: begin wrt = 1; dst = ie[20:16]; src = 1; mr = 1; end
      6'h2B: begin src = 1; mw = 1; end
      6'h04: begin redir = rs_v == rt_v; tgt = npc + sx; end
      6'h05: begin redir = rs_v != rt_v; tgt = npc + sx; end
      6'h02: begin redir = 1; typ = 2; tgt = {npc[31:26], ie[25:0]}; end
      default: ill = 1;
    endcase
    if (ill) begin redir = 1; typ = 3; tgt = 32'h40; end
    if (m_pend) chk_redirect(m_ptype, m_ptgt);
    else if (redir && !st) chk_redirect(typ, tgt);
    else if (!redir) chk("selpc_idle", id_if_selpcsource, 0);
    e_wr = wrt; e_dest = dst; e_src = src; e_mr = mr; e_mw = mw; e_alu = alu;
    e_ops = !ill; e_rega = rs_v; e_regb = rt_v; e_imm = sx;
    if (!m_pend && ill) m_epc = npc - 1;
    if (m_pend) begin
      if (!st) begin m_pend = 0; m_squash = m_ptype == 3; end
    end else if (m_squash) m_squash = 0;
    else if (redir && st) begin m_pend = 1; m_ptype = typ; m_ptgt = tgt; end
    else if (ill) m_squash = 1;
    if (we && wr != 0) m_regs[wr] = wd;
  endtask
  task automatic tick();
    @(posedge clock); #1;
    chk("ex_writereg", id_ex_writereg, e_wr);
    chk("ex_regdest", id_ex_regdest, e_dest);
    chk("ex_alusrc", id_ex_alusrc, e_src);
    chk("ex_memread", id_ex_memread, e_mr);
    chk("ex_memwrite", id_ex_memwrite, e_mw);
    chk("ex_aluop", id_ex_aluop, e_alu);
    chk("epc", id_epc, m_epc);
    if (e_ops) begin
      chk("ex_rega", id_ex_rega, e_rega);
      chk("ex_regb", id_ex_regb, e_regb);
      chk("ex_imedext", id_ex_imedext, e_imm);
    end
  endtask
  task automatic do_reset();
    reset = 0; if_id_instruc = 0; if_id_nextpc = 0; ex_if_stall = 0;
    wb_id_writereg = 0; wb_id_regdest = 0; wb_id_writedata = 0;
    @(posedge clock); #1;
    chk("rst_sel", id_if_selpcsource, 0);
    chk("rst_type", id_if_selpctype, 0);
    chk("rst_pcimd", id_if_pcimd2ext, 0);
    chk("rst_rega_t", id_if_rega, 0);
    chk("rst_pcindex", id_if_pcindex, 0);
    chk("rst_ex_rega", id_ex_rega, 0);
    chk("rst_ex_regb", id_ex_regb, 0);
    chk("rst_ex_imm", id_ex_imedext, 0);
    chk("rst_ctrl", {id_ex_regdest, id_ex_writereg, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_aluop}, 0);
    chk("rst_epc", id_epc, 0);
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    {m_pend, m_squash, m_ptype, m_ptgt, m_epc} = '0;
    {e_wr, e_src, e_mr, e_mw, e_ops, e_rega, e_regb, e_imm, e_dest, e_alu} = '0;
    reset = 1;
  endtask
  function automatic bit [31:0] gen();
    int r;
    bit [4:0] rs, rt, rd;
    bit [15:0] imm;
    bit [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r = $urandom_range(0, 99);
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    if (r < 40) return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
    if (r < 45) return {6'h00, rs, 15'd0, 6'h08};
    if (r < 55) return {6'h08, rs, rt, imm};
    if (r < 62) return {6'h23, rs, rt, imm};
    if (r < 68) return {6'h2B, rs, rt, imm};
    if (r < 76) return {6'h04, rs, rt, imm};
    if (r < 84) return {6'h05, rs, rt, imm};
    if (r < 89) return {6'h02, 26'($urandom)};
    if (r < 94) return 32'h0;
    return r[0] ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h01};
  endfunction
  initial begin
    do_reset();
    drive(32'h0, 32'h0, 0, 0, 0, 0);
    chk("nop_sel", id_if_selpcsource, 0);
    tick();
    drive(32'h0, 32'h1, 0, 1, 3, 5); tick();
    drive(32'h0, 32'h2, 0, 1, 4, 5); tick();
    drive(32'h1064_0004, 32'h11, 0, 0, 0, 0);
    chk("beq_sel", id_if_selpcsource, 1);
    chk("beq_type", id_if_selpctype, 0);
    chk("beq_tgt", id_if_pcimd2ext, 32'h15);
    tick();
    drive(32'h0, 32'h12, 0, 0, 0, 0); tick();
    drive(32'hFC00_0000, 32'h21, 0, 0, 0, 0);
    chk("trap_sel", id_if_selpcsource, 1);
    chk("trap_type", id_if_selpctype, 3);
    tick();
    chk("trap_epc", id_epc, 32'h20);
    chk("trap_bubble", id_ex_writereg, 0);
    drive(32'h0064_3820, 32'h22, 0, 0, 0, 0);
    chk("squash_sel", id_if_selpcsource, 0);
    tick();
    chk("squash_wr", id_ex_writereg, 0);
    drive(32'h0064_3820, 32'h23, 0, 0, 0, 0); tick();
    chk("run_wr", id_ex_writereg, 1);
    chk("run_dest", id_ex_regdest, 7);
    drive(32'h0800_0030, 32'h41, 1, 0, 0, 0); tick();
    drive(32'h0, 32'h42, 1, 0, 0, 0); tick();
    drive(32'h0, 32'h42, 1, 0, 0, 0); tick();
    drive(32'h0, 32'h42, 0, 0, 0, 0);
    chk("jpend_sel", id_if_selpcsource, 1);
    chk("jpend_type", id_if_selpctype, 2);
    chk("jpend_tgt", id_if_pcindex, 32'h30);
    tick();
    drive(32'h0, 32'h31, 0, 0, 0, 0);
    chk("jpend_run", id_if_selpcsource, 0);
    tick();
    drive(32'h00A0_3020, 32'h32, 0, 1, 5, 32'hABCD); tick();
`ifdef DECODE_BYPASS_EN
    chk("bypass_rega", id_ex_rega, 32'hABCD);
`else
    chk("bypass_rega", id_ex_rega, 32'h0);
`endif
    drive(32'h2000_0007, 32'h33, 0, 0, 0, 0); tick();
    drive(32'h0, 32'h34, 0, 1, 0, 32'h99); tick();
    drive(32'h0000_0820, 32'h35, 0, 0, 0, 0); tick();
    chk("r0_rega", id_ex_rega, 0);
    chk("r0_regb", id_ex_regb, 0);
    drive(32'h0800_0030, 32'h41, 1, 0, 0, 0); tick();
    do_reset();
    drive(32'h0, 32'h50, 0, 0, 0, 0);
    chk("rst_pend_sel", id_if_selpcsource, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive(gen(), $urandom, $urandom_range(0, 3) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'($urandom));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage, between instruction fetch and execute. Each cycle it consumes the fetch pipeline register (`if_id_instruc`, `if_id_nextpc`), reads the internal 32×32 register bank, and resolves branch and jump targets. It drives the PC-redirect bus back to fetch combinationally in the same cycle and registers decoded operands and controls into the `id_ex_*` pipeline register. It also owns illegal-opcode trapping, the trap EPC, and redirect requests held across execute stalls.

## Interface
- No parameters; reset vector 32'h0000_0040 and ISA encodings are package constants.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low.
- `if_id_instruc` in 32: instruction from fetch; 32'h0 = nop.
- `if_id_nextpc` in 32: address of that instruction + 1 (word addressing).
- `ex_if_stall` in 1: execute stall; while high, fetch ignores redirects.
- `id_if_selpcsource` out 1: redirect request.
- `id_if_selpctype` out 2: 00 branch, 01 jr, 10 jump, 11 trap vector.
- `id_if_pcimd2ext`, `id_if_rega`, `id_if_pcindex` out 32 each: branch target, jr target, jump target.
- `wb_id_writereg` in 1, `wb_id_regdest` in 5, `wb_id_writedata` in 32: writeback port.
- `id_ex_rega`, `id_ex_regb`, `id_ex_imedext` out 32: operands and sign-extended immediate.
- `id_ex_regdest` out 5; `id_ex_writereg`, `id_ex_alusrc`, `id_ex_memread`, `id_ex_memwrite` out 1; `id_ex_aluop` out 3.
- `id_epc` out 32: address of last trapping instruction.

## Operation
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0], index[25:0].
- Legal: op 00 with funct 20 add, 22 sub, 24 and, 25 or, 2A slt, 08 jr; all-zero word = nop.
- Legal: 08 addi, 23 lw, 2B sw, 04 beq, 05 bne, 02 j.
- Anything else is illegal and traps.
- Targets:
  - `pcimd2ext` = nextpc + sext(imm).
  - `pcindex` = {nextpc[31:26], index}.
  - `rega` = bypassed rs value.
- beq/bne compare bypassed rs/rt in decode. There is no forwarding from execute/memory; software spaces dependent branches.
- One architectural delay slot: the instruction after a branch or jump always executes, except after a trap.
- Register bank: r0 reads 0, and writes to r0 are dropped.
- FSM states:
  - RUN: a taken branch, jump, or trap with `ex_if_stall`=0 asserts `selpcsource` this cycle.
    - Trap → SQUASH.
    - Others stay in RUN.
    - Any redirect with `ex_if_stall`=1 latches type and target → PEND.
  - PEND: re-drives the latched redirect and ignores if_id redirect decode.
    - When `ex_if_stall`=0, fetch takes the redirect → SQUASH if type 11, else RUN.
  - SQUASH: if_id (the delay slot of the trap) is replaced by a bubble, and no redirect is issued → RUN.
- Trap: `id_epc` ← nextpc−1; `id_ex_*` gets a bubble.
- Bubble: all `id_ex` controls 0 and `regdest` 0.
- PEND/SQUASH still forward non-squashed if_id contents to `id_ex`.
- Decoded controls and operands for the current if_id register into `id_ex_*` every cycle; `ex_if_stall` does not freeze this stage.

## Timing
- Redirect outputs are combinational from if_id and state: 0-cycle latency to fetch.
- `id_ex_*` has 1-cycle latency.
- Register write occurs at the rising edge when `wb_id_writereg`=1.
- Reset (synchronous, low): all outputs 0, state RUN, bank cleared, `id_epc` 0.
  - Reset mid-PEND discards the pending redirect.
- Simultaneous writeback and read of the same register: behaviour is defined by the configuration macro.

## Configuration
- `DECODE_BYPASS_EN` defined: a same-cycle writeback to rs/rt is forwarded to operands, compare, and `rega` target.
- Undefined: the old bank value is read, and software needs one extra instruction of spacing.

## Structure
- Shared package holds:
  - opcode/funct constants and aluop codes (add 0, sub 1, and 2, or 3, slt 4);
  - selpctype codes;
  - FSM state enum;
  - the 32'h40 vector.
- Sub-module `reg_bank`: 32×32 bank with 2 read ports and 1 write port; r0 forced to 0; bypass lives inside it under the macro.

## Test plan
- Reset low 1 cycle, then `if_id_instruc`=0 → all outputs 0; nop propagates to `id_ex` with controls 0.
- Write r3=5, r4=5; beq r3,r4,+4 at nextpc 0x11 → `selpcsource`=1, type 00, `pcimd2ext`=0x15 same cycle.
- Illegal op 0x3F at nextpc 0x21 → type 11, `id_epc`=0x20 next edge; following if_id squashed; then RUN.
- j index 0x30 with `ex_if_stall`=1 for 3 cycles → no redirect accepted; redirect re-asserted in the cycle `stall` falls (type 10, 0x30); FSM returns to RUN.
- Writeback r5=0xABCD in the same cycle as `add r6,r5,r0` decode → `id_ex_rega`=0xABCD with macro, old value without.
- `addi r0,r0,7`, then writeback to r0 → subsequent read of r0 = 0.
